// File: rtl/eau_seq_if.sv
// Handshake and strobe bundle between the exchange-unit sequencer and its
// surroundings: CPU request side, byte producer/consumer and exchange unit.
interface eau_seq_if;
    logic       i_start;
    logic       i_dir;
    logic       i_dv;
    logic       i_dr;
    logic       o_busy;
    logic       o_done;
    logic       o_err;
    logic       o_di;
    logic       o_ai;
    logic       o_ls;
    logic       o_hs;
    logic       o_ao;
    logic       o_do;
    logic [2:0] o_state;

    modport master (
        output i_start, i_dir, i_dv, i_dr,
        input  o_busy, o_done, o_err, o_di, o_ai, o_ls, o_hs, o_ao, o_do, o_state
    );

    modport slave (
        input  i_start, i_dir, i_dv, i_dr,
        output o_busy, o_done, o_err, o_di, o_ai, o_ls, o_hs, o_ao, o_do, o_state
    );
endinterface

// File: rtl/eau_seq.sv
// Strobe sequencer for the 16-bit/8-bit exchange unit: two-byte assembly
// (data to address) or split (address to data), with handshake timeout.
module eau_seq #(
    parameter int DRIVE_CYCLES = 1,
    parameter int TIMEOUT      = 255,
    parameter int TW           = 8
) (
    input  logic       clk,
    input  logic       rst,
    eau_seq_if.slave   bus
);
    localparam int DW = (DRIVE_CYCLES > 1) ? $clog2(DRIVE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_LO = 3'd1,
        S_LOAD_HI = 3'd2,
        S_DRIVE   = 3'd3,
        S_CAPTURE = 3'd4,
        S_EMIT_LO = 3'd5,
        S_EMIT_HI = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [TW-1:0]   r_wait;
    logic [TW-1:0]   w_wait_next;
    logic [TW-1:0]   w_wait_inc;
    logic [DW-1:0]   r_drv;
    logic [DW-1:0]   w_drv_next;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic            w_done_next;
    logic            w_err_next;
    logic            w_waiting;
    logic            w_hsk;
    logic            w_di;
    logic            w_ai;
    logic            w_ls;
    logic            w_hs;
    logic            w_ao;
    logic            w_do;

    always_comb begin
        w_next      = r_state;
        w_done_next = 1'b0;
        w_err_next  = 1'b0;
        w_drv_next  = '0;
        w_waiting   = 1'b0;
        w_hsk       = 1'b0;
        w_di        = 1'b0;
        w_ai        = 1'b0;
        w_ls        = 1'b0;
        w_hs        = 1'b0;
        w_ao        = 1'b0;
        w_do        = 1'b0;
        w_wait_inc  = r_wait + TW'(1);
        w_wait_next = '0;

        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_next = bus.i_dir ? S_CAPTURE : S_LOAD_LO;
                end
            end
            S_LOAD_LO: begin
                w_di      = 1'b1;
                w_ls      = bus.i_dv;
                w_waiting = 1'b1;
                w_hsk     = bus.i_dv;
                if (bus.i_dv) w_next = S_LOAD_HI;
            end
            S_LOAD_HI: begin
                w_di      = 1'b1;
                w_hs      = bus.i_dv;
                w_waiting = 1'b1;
                w_hsk     = bus.i_dv;
                if (bus.i_dv) w_next = S_DRIVE;
            end
            S_DRIVE: begin
                w_ao = 1'b1;
                if (r_drv == DW'(DRIVE_CYCLES - 1)) begin
                    w_next      = S_IDLE;
                    w_done_next = 1'b1;
                end else begin
                    w_drv_next = r_drv + DW'(1);
                end
            end
            S_CAPTURE: begin
                w_ai   = 1'b1;
                w_ls   = 1'b1;
                w_hs   = 1'b1;
                w_next = S_EMIT_LO;
            end
            // Emit strobes are gated by dr: each emit edge clears the byte.
            S_EMIT_LO: begin
                w_do      = bus.i_dr;
                w_ls      = bus.i_dr;
                w_waiting = 1'b1;
                w_hsk     = bus.i_dr;
                if (bus.i_dr) w_next = S_EMIT_HI;
            end
            S_EMIT_HI: begin
                w_do      = bus.i_dr;
                w_hs      = bus.i_dr;
                w_waiting = 1'b1;
                w_hsk     = bus.i_dr;
                if (bus.i_dr) begin
                    w_next      = S_IDLE;
                    w_done_next = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase

        // A handshake in the limit cycle never reaches here, so it wins.
        if (w_waiting && !w_hsk) begin
            w_wait_next = w_wait_inc;
            if ((TIMEOUT != 0) && (w_wait_inc == TW'(TIMEOUT))) begin
                w_next      = S_IDLE;
                w_err_next  = 1'b1;
                w_wait_next = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wait  <= '0;
            r_drv   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_next;
            r_drv   <= w_drv_next;
            r_busy  <= (w_next != S_IDLE);
            r_done  <= w_done_next;
            r_err   <= w_err_next;
        end
    end

    assign bus.o_busy  = r_busy;
    assign bus.o_done  = r_done;
    assign bus.o_err   = r_err;
    assign bus.o_di    = w_di;
    assign bus.o_ai    = w_ai;
    assign bus.o_ls    = w_ls;
    assign bus.o_hs    = w_hs;
    assign bus.o_ao    = w_ao;
    assign bus.o_do    = w_do;
    assign bus.o_state = r_state;
endmodule

// File: tb/tb_eau_seq.sv
// Bench for eau_seq: per-cycle vector table with a small exchange-unit data
// model, plus a hand-written timeout sequence.
module tb_eau_seq;
    localparam logic [8:0] E_BUSY = 9'b100000000;
    localparam logic [8:0] E_DN   = 9'b010000000;
    localparam logic [8:0] E_ER   = 9'b001000000;
    localparam logic [8:0] E_DI   = 9'b000100000;
    localparam logic [8:0] E_AI   = 9'b000010000;
    localparam logic [8:0] E_LS   = 9'b000001000;
    localparam logic [8:0] E_HS   = 9'b000000100;
    localparam logic [8:0] E_AO   = 9'b000000010;
    localparam logic [8:0] E_DO   = 9'b000000001;
    localparam logic [4:0] I_RST  = 5'b10000;
    localparam logic [4:0] I_ST   = 5'b01000;
    localparam logic [4:0] I_DIR  = 5'b00100;
    localparam logic [4:0] I_DV   = 5'b00010;
    localparam logic [4:0] I_DR   = 5'b00001;

    typedef struct {
        string       name;
        logic [4:0]  in;
        logic [15:0] din;
        logic [8:0]  exp;
        logic [15:0] exp_data;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic [7:0]  m_lo;
    logic [7:0]  m_hi;
    int          n_checks;
    int          n_fail;
    vec_t        vecs[$];

    eau_seq_if bus ();

    eau_seq #(.DRIVE_CYCLES(2), .TIMEOUT(4), .TW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exchange-unit byte register model driven by the DUT strobes.
    always @(posedge clk) begin
        if (bus.o_di && bus.o_ls) m_lo <= din[7:0];
        if (bus.o_di && bus.o_hs) m_hi <= din[7:0];
        if (bus.o_ai && bus.o_ls) m_lo <= din[7:0];
        if (bus.o_ai && bus.o_hs) m_hi <= din[15:8];
        if (bus.o_do && bus.o_ls) m_lo <= 8'h00;
        if (bus.o_do && bus.o_hs) m_hi <= 8'h00;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [4:0] in, input logic [15:0] d,
                       input logic [8:0] exp, input logic [15:0] exp_data);
        vec_t v;
        v.name = name; v.in = in; v.din = d; v.exp = exp; v.exp_data = exp_data;
        vecs.push_back(v);
    endtask

    function automatic logic [8:0] outs();
        return {bus.o_busy, bus.o_done, bus.o_err, bus.o_di, bus.o_ai,
                bus.o_ls, bus.o_hs, bus.o_ao, bus.o_do};
    endfunction

    initial begin
        logic [7:0] emitted;
        int         load_cycles;
        logic       got_err;
        logic       done_seen;
        logic       strb_seen;

        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; din = '0;
        bus.i_start = 1'b0; bus.i_dir = 1'b0; bus.i_dv = 1'b0; bus.i_dr = 1'b0;

        add("rst_idle", 5'b0, 16'h0, 9'b0, 16'h0);
        // Data to address, dv held high, DRIVE_CYCLES=2.
        add("a0", I_ST | I_DV, 16'h0,    9'b0,                 16'h0);
        add("a1", I_DV,        16'h0034, E_BUSY | E_DI | E_LS, 16'h0);
        add("a2", I_DV,        16'h0012, E_BUSY | E_DI | E_HS, 16'h0);
        add("a3", I_DV,        16'h0,    E_BUSY | E_AO,        16'h1234);
        add("a4", 5'b0,        16'h0,    E_BUSY | E_AO,        16'h1234);
        add("a5", I_ST | I_DIR, 16'h0,   E_DN,                 16'h0);
        // Address to data with a three-cycle consumer stall.
        add("b1", 5'b0, 16'hBEEF, E_BUSY | E_AI | E_LS | E_HS, 16'h0);
        add("b2", 5'b0, 16'h0,    E_BUSY,                      16'h0);
        add("b3", 5'b0, 16'h0,    E_BUSY,                      16'h0);
        add("b4", 5'b0, 16'h0,    E_BUSY,                      16'h0);
        add("b5", I_DR, 16'h0,    E_BUSY | E_DO | E_LS,        16'h00EF);
        add("b6", I_DR, 16'h0,    E_BUSY | E_DO | E_HS,        16'h00BE);
        add("b7", 5'b0, 16'h0,    E_DN,                        16'h0);
        // Start pulsed in EMIT_HI is ignored.
        add("f0", I_ST | I_DIR, 16'h0, 9'b0,                   16'h0);
        add("f1", 5'b0, 16'hA55A, E_BUSY | E_AI | E_LS | E_HS, 16'h0);
        add("f2", I_DR, 16'h0,    E_BUSY | E_DO | E_LS,        16'h005A);
        add("f3", I_DR | I_ST, 16'h0, E_BUSY | E_DO | E_HS,    16'h00A5);
        add("f4", 5'b0, 16'h0,    E_DN,                        16'h0);
        add("f5", 5'b0, 16'h0,    9'b0,                        16'h0);
        // Timeout after four LOAD_LO wait cycles.
        add("c0", I_ST, 16'h0, 9'b0,          16'h0);
        add("c1", 5'b0, 16'h0, E_BUSY | E_DI, 16'h0);
        add("c2", 5'b0, 16'h0, E_BUSY | E_DI, 16'h0);
        add("c3", 5'b0, 16'h0, E_BUSY | E_DI, 16'h0);
        add("c4", 5'b0, 16'h0, E_BUSY | E_DI, 16'h0);
        add("c5", 5'b0, 16'h0, E_ER,          16'h0);
        add("c6", 5'b0, 16'h0, 9'b0,          16'h0);
        // Handshake in the fourth wait cycle, then a LOAD_HI stall.
        add("d0",  I_ST, 16'h0,    9'b0,                 16'h0);
        add("d1",  5'b0, 16'h0,    E_BUSY | E_DI,        16'h0);
        add("d2",  5'b0, 16'h0,    E_BUSY | E_DI,        16'h0);
        add("d3",  5'b0, 16'h0,    E_BUSY | E_DI,        16'h0);
        add("d4",  I_DV, 16'h0078, E_BUSY | E_DI | E_LS, 16'h0);
        add("d5",  5'b0, 16'h0,    E_BUSY | E_DI,        16'h0);
        add("d6",  5'b0, 16'h0,    E_BUSY | E_DI,        16'h0);
        add("d7",  5'b0, 16'h0,    E_BUSY | E_DI,        16'h0);
        add("d8",  I_DV, 16'h0056, E_BUSY | E_DI | E_HS, 16'h0);
        add("d9",  5'b0, 16'h0,    E_BUSY | E_AO,        16'h5678);
        add("d10", 5'b0, 16'h0,    E_BUSY | E_AO,        16'h5678);
        add("d11", 5'b0, 16'h0,    E_DN,                 16'h0);
        // Reset while in LOAD_HI, then a normal address-to-data transfer.
        add("r0", I_ST | I_DV,  16'h0,    9'b0,                        16'h0);
        add("r1", I_DV,         16'h0011, E_BUSY | E_DI | E_LS,        16'h0);
        add("r2", I_RST,        16'h0,    E_BUSY | E_DI,               16'h0);
        add("r3", I_ST | I_DIR, 16'h0,    9'b0,                        16'h0);
        add("r4", 5'b0,         16'hC3D2, E_BUSY | E_AI | E_LS | E_HS, 16'h0);
        add("r5", I_DR,         16'h0,    E_BUSY | E_DO | E_LS,        16'h00D2);
        add("r6", I_DR,         16'h0,    E_BUSY | E_DO | E_HS,        16'h00C3);
        add("r7", 5'b0,         16'h0,    E_DN,                        16'h0);
        add("r8", 5'b0,         16'h0,    9'b0,                        16'h0);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            rst         = vecs[i].in[4];
            bus.i_start = vecs[i].in[3];
            bus.i_dir   = vecs[i].in[2];
            bus.i_dv    = vecs[i].in[1];
            bus.i_dr    = vecs[i].in[0];
            din         = vecs[i].din;
            @(negedge clk);
            check({vecs[i].name, "_outs"}, {7'b0, outs()}, {7'b0, vecs[i].exp});
            if ((vecs[i].exp & E_AO) != 9'b0)
                check({vecs[i].name, "_addr"}, {m_hi, m_lo}, vecs[i].exp_data);
            if ((vecs[i].exp & E_DO) != 9'b0) begin
                emitted = bus.o_ls ? m_lo : m_hi;
                check({vecs[i].name, "_byte"}, {8'h00, emitted}, vecs[i].exp_data);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        bus.i_start = 1'b0; bus.i_dir = 1'b0; bus.i_dv = 1'b0; bus.i_dr = 1'b0;

        @(negedge clk);
        check("idle_state", {13'b0, bus.o_state}, 16'h0000);
        @(posedge clk);
        #1;

        // Timeout again, observed free-running with a bounded wait.
        load_cycles = 0; got_err = 1'b0; done_seen = 1'b0; strb_seen = 1'b0;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.o_busy && bus.o_di) load_cycles++;
            if (bus.o_done) done_seen = 1'b1;
            if (bus.o_ls || bus.o_hs || bus.o_ao) strb_seen = 1'b1;
            if (bus.o_err) begin
                got_err = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("to_err_seen", {15'b0, got_err}, 16'h0001);
        check("to_load_cycles", load_cycles[15:0], 16'd4);
        check("to_no_done", {15'b0, done_seen}, 16'h0000);
        check("to_no_strobes", {15'b0, strb_seen}, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/eau_seq.md
# eau_seq

Control sequencer for the 16-bit/8-bit bus exchange unit. It turns a single `start` request into the cycle-exact strobe sequence (`di`, `ai`, `ls`, `hs`, `ao`, `do`) the exchange unit needs to move a 16-bit value in two byte transfers, in either direction:

- **Data bus to address bus:** assemble two data-bus bytes into an address-bus word.
- **Address bus to data bus:** split an address-bus word into two data-bus bytes.

It handshakes with the byte producer or consumer on the data bus and reports completion or timeout to the CPU control logic.

## Interface
Parameters:
- DRIVE_CYCLES, default 1: number of cycles `ao` is held after a data-to-address assembly. Must be ≥1.
- TIMEOUT, default 255: number of consecutive handshake-wait cycles before abort. 0 disables the timeout.
- TW, default 8: width of the wait counter. Requires TIMEOUT < 2^TW.

Ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  transfer request; sampled only in IDLE.
- dir  in  1  direction, sampled with `start`: 0 = data-to-address, 1 = address-to-data.
- dv  in  1  producer byte valid (data-to-address only).
- dr  in  1  consumer ready (address-to-data only).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on timeout abort.
- di, ai, ls, hs, ao, do  out  1 each  strobes to the exchange unit.

## Operation
- States: IDLE, LOAD_LO, LOAD_HI, DRIVE, CAPTURE, EMIT_LO, EMIT_HI.
- **IDLE:** all strobes 0.
  - `start=1`, `dir=0` → LOAD_LO.
  - `start=1`, `dir=1` → CAPTURE.
- **LOAD_LO:** `di=1`, `ls=dv`. On `dv=1` → LOAD_HI.
- **LOAD_HI:** `di=1`, `hs=dv`. On `dv=1` → DRIVE.
- **DRIVE:** `ao=1` for exactly DRIVE_CYCLES cycles, then → IDLE with `done`.
- **CAPTURE:** `ai=1`, `ls=1`, `hs=1` for one cycle → EMIT_LO.
- **EMIT_LO:** `do=dr`, `ls=dr`, `ai=0`. On `dr=1` → EMIT_HI.
- **EMIT_HI:** `do=dr`, `hs=dr`, `ai=0`. On `dr=1` → IDLE with `done`.
- **Destructive reads:** an emit edge reloads the selected exchange-unit byte with 0, so strobes in EMIT states are gated by `dr`. A byte is never emitted twice per capture.
- **Byte order:** always low byte first, then high byte.
- **Strobe exclusivity:** `ls`, `hs`, `ao`, `do`, `di`, `ai` assert only in the states listed above. `ao` and `do` are never high in the same cycle.
- **Wait counter:**
  - Counts consecutive cycles in LOAD_LO, LOAD_HI, EMIT_LO or EMIT_HI where the relevant `dv`/`dr` is 0.
  - Clears on any handshake or state change.
  - When TIMEOUT≠0 and the count reaches TIMEOUT: → IDLE, `err` pulses, no `done`.
  - A handshake in the same cycle the count would reach TIMEOUT wins: the state advances and there is no error.
- **Ignored inputs:**
  - `start` outside IDLE is ignored; it is neither queued nor flagged.
  - `dv` outside LOAD states and `dr` outside EMIT states are ignored.
- **Reset:** the edge with `rst=1` forces IDLE and clears the counters, `done` and `err`. From the following cycle all outputs are 0. This applies mid-transfer too; a partially loaded word is abandoned.

## Timing
- **Strobe timing:** strobes decode from state plus same-cycle `dv`/`dr`. A producer or consumer byte is transferred at the edge that ends the cycle in which its handshake is high.
- **`done` / `err`:** registered. High during the first IDLE cycle after completion or abort. A new `start` is accepted in that same cycle.
- **Data-to-address latency, with `dv` held 1:**
  - `start` sampled at edge 0.
  - LOAD_LO in cycle 1, LOAD_HI in cycle 2.
  - DRIVE in cycles 3..2+DRIVE_CYCLES.
  - `done` in cycle 3+DRIVE_CYCLES.
- **Address-to-data latency, with `dr` held 1:** CAPTURE in cycle 1, EMIT_LO in cycle 2, EMIT_HI in cycle 3, `done` in cycle 4.
- **Throughput:** back-to-back starts give no idle gap beyond the `done` cycle.
- **`busy`:** equals (state ≠ IDLE), registered with the state.

## Test plan
- **Data-to-address, no stalls:** DRIVE_CYCLES=2, `dir=0`, `dv`=1 throughout, producer bytes 0x34 then 0x12 → `ls` in cycle 1, `hs` in cycle 2, `ao` in cycles 3–4, exchange-unit address output 0x1234, `done` in cycle 5.
- **Address-to-data with consumer stall:** `dir=1`, address 0xBEEF, `dr` low for 3 cycles in EMIT_LO → `do`/`ls` stay 0 during the stall. Consumer sees 0xEF on the first `dr` cycle, then 0xBE, then `done`.
- **Timeout:** TIMEOUT=4, `dir=0`, `dv` held 0 → exactly 4 cycles in LOAD_LO, then `err` pulse in IDLE, `done` never asserted, `ls`/`hs`/`ao` never asserted.
- **Handshake at limit:** TIMEOUT=4, `dv` rises in the 4th wait cycle → LOAD_HI entered, no `err`.
- **Reset mid-op:** `rst=1` for one cycle while in LOAD_HI → next cycle IDLE, all outputs 0, `busy=0`. A following `start` with `dir=1` runs normally.
- **Ignored start:** `start` pulsed while in EMIT_HI → no effect on sequence. Exactly one `done` is produced.
